mprj_pwr_monitor: RTL and testbench
===================================

Name: mprj_pwr_monitor

Overview:
- Parametrised power-good monitor for N user-project 3.3V domains.
- Inputs are the level-shifted "domain logic high" signals. These are asynchronous to the core clock and glitch on ramp.
- Per channel: synchronises, debounces power-up, detects power loss immediately, and flags loss with sticky status and an interrupt.
- Sits in the 1.8V core domain between the HV level shifters and the management protection / housekeeping logic.

Parameters:
- N_DOMAINS, 2, number of monitored user power domains (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_W, 8, width of each debounce counter.
- DEBOUNCE_CYCLES, 100, consecutive synchronised-high cycles required before power-good asserts (1 .. 2^DEBOUNCE_W-1).

Ports:
- clock  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- vdd_logic1  input  N_DOMAINS  async level-shifted domain-high signals.
- chan_en  input  N_DOMAINS  per-channel monitor enable (synchronous to clock).
- lost_clr  input  N_DOMAINS  write-one-clear pulses for the lost flags.
- irq_en  input  N_DOMAINS  per-channel interrupt enable.
- pwr_good  output  N_DOMAINS  debounced power-good per domain.
- pg_rise  output  N_DOMAINS  1-cycle pulse when pwr_good rises.
- pg_fall  output  N_DOMAINS  1-cycle pulse when pwr_good falls.
- lost  output  N_DOMAINS  sticky power-loss flag.
- all_good  output  1  all enabled domains good.
- irq  output  1  registered interrupt.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. All flops clear on reset assertion and release synchronously with clock.
- Reset values: pwr_good=0, pg_rise=0, pg_fall=0, lost=0, all_good=0, irq=0, all sync flops=0, counters=0, state=OFF.
- Synchroniser: vdd_logic1[i] passes through SYNC_STAGES flops. Call the last stage s[i]. Nothing downstream uses an unsynchronised input.
- Per-channel FSM: three states, OFF, RAMP and ON.
  - OFF: cnt=0, pwr_good=0. If chan_en[i] and s[i]=1, go to RAMP with cnt=1.
  - RAMP: if s[i]=1, cnt increments. When cnt==DEBOUNCE_CYCLES, go to ON. If s[i]=0, go to OFF with cnt=0 (any glitch restarts the count). There are no events in RAMP.
  - ON: pwr_good=1, cnt holds. If s[i]=0, go to OFF on the next edge. This loss path is deliberately not debounced.
- Power-up latency: with s[i] high continuously from cycle t (first cycle seen high), pwr_good[i] is high from cycle t+DEBOUNCE_CYCLES. Total from a clean input edge is SYNC_STAGES+DEBOUNCE_CYCLES cycles, up to 1 cycle of sampling uncertainty.
- DEBOUNCE_CYCLES=1 special case: RAMP goes to ON on the first high cycle in RAMP.
- Counter: saturating compare only. It never wraps, because cnt<=DEBOUNCE_CYCLES<2^DEBOUNCE_W.
- pg_rise[i]: high for exactly one cycle, in the same cycle pwr_good[i] first reads 1.
- pg_fall[i]: high for exactly one cycle, in the cycle pwr_good[i] first reads 0 after ON to OFF.
- lost[i]:
  - Set in the same cycle as pg_fall[i], but only on an ON to OFF exit caused by s[i]=0.
  - Cleared by lost_clr[i]=1.
  - Set and clear in the same cycle: set wins, lost stays 1.
  - Exits caused by chan_en deassertion do not set lost.
- chan_en[i]=0:
  - From any state, go to OFF on the next edge with cnt=0.
  - If leaving ON, pwr_good drops and pg_fall pulses, but lost is not set.
  - While disabled, the channel holds OFF and generates no events.
  - lost[i] keeps its value and can still be cleared.
- all_good: computed combinationally from registered state. It is 1 iff at least one chan_en bit is 1 and, for every i, pwr_good[i] | ~chan_en[i]. If no channel is enabled, all_good=0.
- irq: registered, irq <= |(lost & irq_en). It follows lost with 1 cycle of latency and is level-type (stays high until the flags are cleared).
- Reset mid-operation: all outputs drop to reset values immediately (asynchronously). No pg_fall pulse and no lost set are generated by reset.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses and flags.

Test Plan (N_DOMAINS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, chan_en=2'b11, irq_en=2'b11 unless stated):
- Clean power-up: vdd_logic1[0] rises and stays high. pwr_good[0] goes to 1 exactly 6 cycles after the input edge, pg_rise[0] pulses once with it, all_good stays 0 while vdd_logic1[1]=0, and then goes to 1 once channel 1 also completes.
- Glitch during ramp: input high for 3 synchronised cycles, low for 1, then high. The count restarts, pwr_good rises 4 cycles after the second rise reaches s, and there is no pg_fall or lost.
- Power loss: channel ON, then vdd_logic1[0] drops. pwr_good[0] goes to 0 three cycles after the input edge, pg_fall[0] and lost[0] set in that same cycle, and irq goes to 1 one cycle later.
- Sticky clear race: lost[0]=1 and the input toggles to cause a new loss in the same cycle as lost_clr[0]=1, so lost[0] stays 1. Then a lost_clr[0] pulse with no event gives lost[0]=0, and irq=0 on the next cycle.
- Disable while ON: chan_en[1] goes to 0. pwr_good[1] goes to 0 and pg_fall[1] pulses, lost[1] stays 0, and all_good follows channel 0 only. Setting chan_en=0 gives all_good=0.
- Reset mid-ramp and mid-ON: assert reset asynchronously. All outputs go to 0 without waiting for a clock edge, with no pulses. After release with the input high, the full 6-cycle latency applies again.

Source files
------------

// File: rtl/mprj_pwr_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : mprj_pwr_monitor_if
// Description : Status/control bundle between the power monitor and its host.
// Revision    : 1.0 - initial release
// ============================================================================
interface mprj_pwr_monitor_if #(
  parameter int N_DOMAINS = 2
);
  logic [N_DOMAINS-1:0] vdd_logic1;
  logic [N_DOMAINS-1:0] chan_en;
  logic [N_DOMAINS-1:0] lost_clr;
  logic [N_DOMAINS-1:0] irq_en;
  logic [N_DOMAINS-1:0] pwr_good;
  logic [N_DOMAINS-1:0] pg_rise;
  logic [N_DOMAINS-1:0] pg_fall;
  logic [N_DOMAINS-1:0] lost;
  logic                 all_good;
  logic                 irq;

  modport master (
    output vdd_logic1, chan_en, lost_clr, irq_en,
    input  pwr_good, pg_rise, pg_fall, lost, all_good, irq
  );

  modport slave (
    input  vdd_logic1, chan_en, lost_clr, irq_en,
    output pwr_good, pg_rise, pg_fall, lost, all_good, irq
  );
endinterface
`default_nettype wire

// File: rtl/mprj_pwr_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mprj_pwr_monitor
// Description : Per-domain power-good monitor: sync, debounced power-up,
//               immediate loss detection, sticky lost flags and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module mprj_pwr_monitor #(
  parameter int N_DOMAINS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_W      = 8,
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic                clock,
  input  logic                reset,
  mprj_pwr_monitor_if.slave   mon
);

  localparam logic [DEBOUNCE_W-1:0] c_cnt_last = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] c_cnt_done = DEBOUNCE_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  logic [N_DOMAINS-1:0] w_pwr_good;
  logic [N_DOMAINS-1:0] w_pg_rise;
  logic [N_DOMAINS-1:0] w_pg_fall;
  logic [N_DOMAINS-1:0] w_lost;
  logic                 irq_q;

  for (genvar i = 0; i < N_DOMAINS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_s;
    state_t                 state_q;
    logic [DEBOUNCE_W-1:0]  cnt_q;
    logic                   pwr_good_q;
    logic                   pg_rise_q;
    logic                   pg_fall_q;
    logic                   lost_q;
    logic                   lost_d;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], mon.vdd_logic1[i]};
    end

    assign w_s = sync_q[SYNC_STAGES-1];

    // Only a loss seen on the supply itself is sticky; disabling is not a loss.
    assign lost_d = ((state_q == ST_ON) && mon.chan_en[i] && !w_s)
                  || (lost_q && !mon.lost_clr[i]);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q    <= ST_OFF;
        cnt_q      <= '0;
        pwr_good_q <= 1'b0;
        pg_rise_q  <= 1'b0;
        pg_fall_q  <= 1'b0;
        lost_q     <= 1'b0;
      end else begin
        pg_rise_q <= 1'b0;
        pg_fall_q <= 1'b0;
        lost_q    <= lost_d;
        if (!mon.chan_en[i]) begin
          state_q    <= ST_OFF;
          cnt_q      <= '0;
          pwr_good_q <= 1'b0;
          pg_fall_q  <= (state_q == ST_ON);
        end else begin
          case (state_q)
            ST_OFF: begin
              if (w_s) begin
                state_q <= ST_RAMP;
                cnt_q   <= DEBOUNCE_W'(1);
              end
            end
            ST_RAMP: begin
              if (!w_s) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
              end else if (cnt_q >= c_cnt_last) begin
                state_q    <= ST_ON;
                cnt_q      <= c_cnt_done;
                pwr_good_q <= 1'b1;
                pg_rise_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + DEBOUNCE_W'(1);
              end
            end
            ST_ON: begin
              if (!w_s) begin
                state_q    <= ST_OFF;
                cnt_q      <= '0;
                pwr_good_q <= 1'b0;
                pg_fall_q  <= 1'b1;
              end
            end
            default: begin
              state_q    <= ST_OFF;
              cnt_q      <= '0;
              pwr_good_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign w_pwr_good[i] = pwr_good_q;
    assign w_pg_rise[i]  = pg_rise_q;
    assign w_pg_fall[i]  = pg_fall_q;
    assign w_lost[i]     = lost_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= |(w_lost & mon.irq_en);
  end

  assign mon.pwr_good = w_pwr_good;
  assign mon.pg_rise  = w_pg_rise;
  assign mon.pg_fall  = w_pg_fall;
  assign mon.lost     = w_lost;
  assign mon.irq      = irq_q;
  assign mon.all_good = (|mon.chan_en) & (&(w_pwr_good | ~mon.chan_en));

endmodule
`default_nettype wire

// File: tb/tb_mprj_pwr_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_mprj_pwr_monitor
// Description : Self-checking bench with a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mprj_pwr_monitor;
  localparam int N  = 2;
  localparam int SS = 2;
  localparam int D  = 4;
  localparam int W  = 8;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mprj_pwr_monitor_if #(.N_DOMAINS(N)) mon ();

  mprj_pwr_monitor #(
    .N_DOMAINS(N), .SYNC_STAGES(SS), .DEBOUNCE_W(W), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mon   (mon)
  );

  // Reference: power is good once the channel has seen D consecutive enabled
  // cycles with the synchronised input high.
  logic [N-1:0] m_pipe [SS];
  int           m_run  [N];
  logic [N-1:0] m_good, m_rise, m_fall, m_lost;
  logic         m_irq;

  logic [4*N+1:0] w_act, w_exp;
  assign w_act = {mon.pwr_good, mon.pg_rise, mon.pg_fall, mon.lost, mon.all_good, mon.irq};
  assign w_exp = {m_good, m_rise, m_fall, m_lost,
                  (|mon.chan_en) & (&(m_good | ~mon.chan_en)), m_irq};

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_good = '0; m_rise = '0; m_fall = '0; m_lost = '0; m_irq = 1'b0;
  endtask

  task automatic model_update();
    logic [N-1:0] n_good, n_lost;
    logic         s_old;
    for (int i = 0; i < N; i++) begin
      s_old = m_pipe[SS-1][i];
      if (mon.chan_en[i] && s_old) m_run[i] = (m_run[i] < D) ? m_run[i] + 1 : D;
      else                          m_run[i] = 0;
      n_good[i] = (m_run[i] >= D);
      m_rise[i] = n_good[i] & ~m_good[i];
      m_fall[i] = ~n_good[i] & m_good[i];
      n_lost[i] = (m_fall[i] & mon.chan_en[i] & ~s_old) | (m_lost[i] & ~mon.lost_clr[i]);
    end
    m_irq  = |(m_lost & mon.irq_en);
    m_lost = n_lost;
    m_good = n_good;
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = mon.vdd_logic1;
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) model_reset();
    else       model_update();
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (w_act !== '0) begin errors++; $display("FAIL reset_async: got %b exp 0", w_act); end
    repeat (3) begin
      step();
      checks++;
      if (w_act !== '0) begin errors++; $display("FAIL reset_hold: got %b exp 0", w_act); end
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    mon.vdd_logic1[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL pu0_model c%0d: got %b exp %b", c, w_act, w_exp); end
      if (c == 5) begin
        checks++;
        if (mon.pwr_good[0] !== 1'b0) begin errors++; $display("FAIL pu0_early: got %b exp 0", mon.pwr_good[0]); end
      end
    end
    checks++;
    if ({mon.pwr_good[0], mon.pg_rise[0], mon.all_good} !== 3'b110)
      begin errors++; $display("FAIL pu0_rise: got %b exp 110", {mon.pwr_good[0], mon.pg_rise[0], mon.all_good}); end
    step();
    checks++;
    if (mon.pg_rise[0] !== 1'b0) begin errors++; $display("FAIL pu0_pulse_width: got %b exp 0", mon.pg_rise[0]); end
    mon.vdd_logic1[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL pu1_model c%0d: got %b exp %b", c, w_act, w_exp); end
    end
    checks++;
    if ({mon.pwr_good, mon.all_good} !== 3'b111)
      begin errors++; $display("FAIL pu_all_good: got %b exp 111", {mon.pwr_good, mon.all_good}); end
  endtask

  task automatic test_loss();
    mon.vdd_logic1[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL loss_model c%0d: got %b exp %b", c, w_act, w_exp); end
      if (c == 2) begin
        checks++;
        if (mon.pwr_good[0] !== 1'b1) begin errors++; $display("FAIL loss_early: got %b exp 1", mon.pwr_good[0]); end
      end
    end
    checks++;
    if ({mon.pwr_good[0], mon.pg_fall[0], mon.lost[0], mon.irq} !== 4'b0110)
      begin errors++; $display("FAIL loss_flags: got %b exp 0110", {mon.pwr_good[0], mon.pg_fall[0], mon.lost[0], mon.irq}); end
    step();
    checks++;
    if ({mon.pg_fall[0], mon.irq} !== 2'b01)
      begin errors++; $display("FAIL loss_irq: got %b exp 01", {mon.pg_fall[0], mon.irq}); end
  endtask

  task automatic test_sticky_race();
    mon.vdd_logic1[0] = 1'b1;
    repeat (6) step();
    checks++;
    if (w_act !== w_exp) begin errors++; $display("FAIL race_up: got %b exp %b", w_act, w_exp); end
    mon.vdd_logic1[0] = 1'b0;
    repeat (2) step();
    mon.lost_clr = 2'b01;
    step();
    mon.lost_clr = 2'b00;
    checks++;
    if ({mon.pg_fall[0], mon.lost[0]} !== 2'b11)
      begin errors++; $display("FAIL race_set_wins: got %b exp 11", {mon.pg_fall[0], mon.lost[0]}); end
    repeat (2) step();
    mon.lost_clr = 2'b01;
    step();
    mon.lost_clr = 2'b00;
    checks++;
    if ({mon.lost[0], mon.irq} !== 2'b01)
      begin errors++; $display("FAIL race_clear: got %b exp 01", {mon.lost[0], mon.irq}); end
    step();
    checks++;
    if (mon.irq !== 1'b0) begin errors++; $display("FAIL race_irq_drop: got %b exp 0", mon.irq); end
    checks++;
    if (w_act !== w_exp) begin errors++; $display("FAIL race_model: got %b exp %b", w_act, w_exp); end
  endtask

  task automatic test_glitch();
    mon.vdd_logic1[0] = 1'b1;
    repeat (3) step();
    mon.vdd_logic1[0] = 1'b0;
    step();
    mon.vdd_logic1[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL glitch_model c%0d: got %b exp %b", c, w_act, w_exp); end
      if (c == 5) begin
        checks++;
        if (mon.pwr_good[0] !== 1'b0) begin errors++; $display("FAIL glitch_early: got %b exp 0", mon.pwr_good[0]); end
      end
    end
    checks++;
    if ({mon.pwr_good[0], mon.pg_fall[0], mon.lost[0]} !== 3'b100)
      begin errors++; $display("FAIL glitch_done: got %b exp 100", {mon.pwr_good[0], mon.pg_fall[0], mon.lost[0]}); end
  endtask

  task automatic test_disable();
    mon.chan_en = 2'b01;
    step();
    checks++;
    if ({mon.pwr_good[1], mon.pg_fall[1], mon.lost[1], mon.all_good} !== 4'b0101)
      begin errors++; $display("FAIL dis_ch1: got %b exp 0101", {mon.pwr_good[1], mon.pg_fall[1], mon.lost[1], mon.all_good}); end
    step();
    checks++;
    if (w_act !== w_exp) begin errors++; $display("FAIL dis_hold: got %b exp %b", w_act, w_exp); end
    mon.chan_en = 2'b00;
    #1;
    checks++;
    if (mon.all_good !== 1'b0) begin errors++; $display("FAIL dis_none: got %b exp 0", mon.all_good); end
    repeat (3) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL dis_all: got %b exp %b", w_act, w_exp); end
    end
    mon.chan_en = 2'b11;
    repeat (6) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL dis_restore: got %b exp %b", w_act, w_exp); end
    end
  endtask

  task automatic test_reset_mid();
    mon.vdd_logic1[0] = 1'b0;
    repeat (3) step();
    mon.vdd_logic1[0] = 1'b1;
    repeat (5) step();
    checks++;
    if (w_act !== w_exp) begin errors++; $display("FAIL rmid_pre: got %b exp %b", w_act, w_exp); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (w_act !== '0) begin errors++; $display("FAIL rmid_async: got %b exp 0", w_act); end
    repeat (2) step();
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL rmid_model c%0d: got %b exp %b", c, w_act, w_exp); end
      if (c == 5) begin
        checks++;
        if (mon.pwr_good !== 2'b00) begin errors++; $display("FAIL rmid_early: got %b exp 00", mon.pwr_good); end
      end
    end
    checks++;
    if ({mon.pwr_good, mon.pg_rise} !== 4'b1111)
      begin errors++; $display("FAIL rmid_latency: got %b exp 1111", {mon.pwr_good, mon.pg_rise}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0)  mon.vdd_logic1[i] = ~mon.vdd_logic1[i];
        if ($urandom_range(0, 39) == 0) mon.chan_en[i]    = ~mon.chan_en[i];
        if ($urandom_range(0, 29) == 0) mon.irq_en[i]     = ~mon.irq_en[i];
        mon.lost_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (w_act !== '0) begin errors++; $display("FAIL rand_reset n%0d: got %b exp 0", n, w_act); end
        step();
        reset = 1'b0;
      end
      step();
      checks++;
      if (w_act !== w_exp) begin errors++; $display("FAIL rand n%0d: got %b exp %b", n, w_act, w_exp); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    mon.vdd_logic1 = '0;
    mon.chan_en    = 2'b11;
    mon.lost_clr   = '0;
    mon.irq_en     = 2'b11;
    model_reset();
    test_reset();
    test_power_up();
    test_loss();
    test_sticky_race();
    test_glitch();
    test_disable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
